// File: rtl/control_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// control_sequencer : multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM
// Revision 1.0
// ----------------------------------------------------------------------------
module control_sequencer #(
  parameter int TIMEOUT_CYC     = 16,
  parameter int CNT_W           = 32,
  parameter int TRAP_ON_ILLEGAL = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             F_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             dmu_wen,
  output logic             pc_inc,
  output logic             pc_ld,
  output logic             ir_ld,
  output logic             write,
  output logic             reg_dst,
  output logic             mux_a,
  output logic             mux_b,
  output logic             mux_im_1,
  output logic [1:0]       mux_im_2,
  output logic [1:0]       bus_sel,
  output logic [1:0]       alu_op,
  output logic             halted,
  output logic             trap,
  output logic [1:0]       trap_code,
  output logic [CNT_W-1:0] instr_retired
);

  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_lui   = 6'h0F;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2B;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_j     = 6'h02;
  localparam logic [5:0] c_op_halt  = 6'h3F;

  localparam logic [7:0] c_wait_limit = 8'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] c_one  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_wait_cnt;
  logic [CNT_W-1:0] r_retired;
  logic [1:0]       r_trap_code;
  logic [1:0]       w_next_trap_code;

  logic w_is_r, w_is_addi, w_is_lui, w_is_lw, w_is_sw, w_is_beq, w_is_j, w_is_halt;
  logic w_funct_ok, w_legal, w_illegal_traps;
  logic [1:0] w_alu_r;
  logic w_in_wait, w_enter_wait, w_wait_expired;

  generate
    if (TRAP_ON_ILLEGAL != 0) begin : g_illegal_trap
      assign w_illegal_traps = 1'b1;
    end else begin : g_illegal_nop
      assign w_illegal_traps = 1'b0;
    end
  endgenerate

  assign w_is_r    = (opcode == c_op_rtype);
  assign w_is_addi = (opcode == c_op_addi);
  assign w_is_lui  = (opcode == c_op_lui);
  assign w_is_lw   = (opcode == c_op_lw);
  assign w_is_sw   = (opcode == c_op_sw);
  assign w_is_beq  = (opcode == c_op_beq);
  assign w_is_j    = (opcode == c_op_j);
  assign w_is_halt = (opcode == c_op_halt);

  always_comb begin
    w_alu_r    = 2'b00;
    w_funct_ok = 1'b1;
    case (funct)
      6'h20:   w_alu_r = 2'b00;
      6'h22:   w_alu_r = 2'b01;
      6'h24:   w_alu_r = 2'b10;
      6'h25:   w_alu_r = 2'b11;
      default: w_funct_ok = 1'b0;
    endcase
  end

  assign w_legal = (w_is_r && w_funct_ok) || w_is_addi || w_is_lui || w_is_lw ||
                   w_is_sw || w_is_beq || w_is_j || w_is_halt;

  // The limit is reached on the TIMEOUT_CYC-th consecutive not-ready cycle.
  assign w_wait_expired = (r_wait_cnt == c_wait_limit) && !mem_ready;
  assign w_in_wait      = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_enter_wait   = ((w_next == S_FETCH) || (w_next == S_MEM)) && (w_next != r_state);

  always_comb begin
    w_next           = r_state;
    w_next_trap_code = r_trap_code;
    case (r_state)
      S_FETCH: begin
        if (mem_ready) begin
          w_next = S_DECODE;
        end else if (w_wait_expired) begin
          w_next           = S_TRAP;
          w_next_trap_code = 2'b01;
        end
      end
      S_DECODE: begin
        if (w_is_halt) begin
          w_next = S_HALT;
        end else if (w_is_j) begin
          w_next = S_FETCH;
        end else if (!w_legal) begin
          if (w_illegal_traps) begin
            w_next           = S_TRAP;
            w_next_trap_code = 2'b11;
          end else begin
            w_next = S_FETCH;
          end
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_is_lw || w_is_sw) begin
          w_next = S_MEM;
        end else if (w_is_beq) begin
          w_next = S_FETCH;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          w_next = w_is_sw ? S_FETCH : S_WB;
        end else if (w_wait_expired) begin
          w_next           = S_TRAP;
          w_next_trap_code = 2'b10;
        end
      end
      S_WB:    w_next = S_FETCH;
      default: w_next = r_state;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state     <= S_FETCH;
      r_wait_cnt  <= 8'd0;
      r_retired   <= '0;
      r_trap_code <= 2'b00;
    end else begin
      r_state     <= w_next;
      r_trap_code <= w_next_trap_code;
      if (w_enter_wait) begin
        r_wait_cnt <= 8'd0;
      end else if (w_in_wait && !mem_ready) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
      // Every return to FETCH completes an instruction; waiting in FETCH does not.
      if ((w_next == S_FETCH) && (r_state != S_FETCH)) begin
        r_retired <= r_retired + c_one;
      end
    end
  end

  always_comb begin
    mem_req  = 1'b0;
    dmu_wen  = 1'b0;
    pc_inc   = 1'b0;
    pc_ld    = 1'b0;
    ir_ld    = 1'b0;
    write    = 1'b0;
    reg_dst  = 1'b0;
    mux_a    = 1'b0;
    mux_b    = 1'b0;
    mux_im_1 = 1'b0;
    mux_im_2 = 2'b00;
    bus_sel  = 2'b00;
    alu_op   = 2'b00;
    halted   = 1'b0;
    trap     = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        bus_sel = 2'b00;
        ir_ld   = mem_ready;
        pc_inc  = mem_ready;
      end
      S_DECODE: begin
        mux_a = 1'b0;
        mux_b = 1'b0;
        pc_ld = w_is_j;
      end
      S_EXEC: begin
        if (w_is_r) begin
          alu_op = w_alu_r;
        end
        if (w_is_addi || w_is_lw || w_is_sw) begin
          mux_im_2 = 2'b01;
          alu_op   = 2'b00;
        end
        if (w_is_lui) begin
          mux_im_1 = 1'b1;
          mux_im_2 = 2'b10;
          alu_op   = 2'b10;
        end
        if (w_is_beq) begin
          alu_op = 2'b01;
          pc_ld  = F_zero;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        dmu_wen = w_is_sw;
      end
      S_WB: begin
        write   = 1'b1;
        bus_sel = w_is_lw ? 2'b01 : 2'b10;
        reg_dst = w_is_r;
      end
      S_HALT:  halted = 1'b1;
      S_TRAP:  trap   = 1'b1;
      default: ;
    endcase
  end

  assign trap_code     = r_trap_code;
  assign instr_retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_control_sequencer : directed-vector bench for control_sequencer
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_control_sequencer;

  // Packed control vector layout: {mem_req,dmu_wen,pc_inc,pc_ld,ir_ld,write,
  // reg_dst,mux_a,mux_b,mux_im_1,mux_im_2[1:0],bus_sel[1:0],alu_op[1:0],halted,trap}
  localparam logic [17:0] M_MREQ   = 18'h20000;
  localparam logic [17:0] M_DMU    = 18'h10000;
  localparam logic [17:0] M_PINC   = 18'h08000;
  localparam logic [17:0] M_PLD    = 18'h04000;
  localparam logic [17:0] M_ILD    = 18'h02000;
  localparam logic [17:0] M_WR     = 18'h01000;
  localparam logic [17:0] M_RDST   = 18'h00800;
  localparam logic [17:0] M_IM1    = 18'h00100;
  localparam logic [17:0] IM2_IMM  = 18'h00040;
  localparam logic [17:0] IM2_ONES = 18'h00080;
  localparam logic [17:0] BUS_MEM  = 18'h00010;
  localparam logic [17:0] BUS_ALU  = 18'h00020;
  localparam logic [17:0] ALU_SUB  = 18'h00004;
  localparam logic [17:0] ALU_AND  = 18'h00008;
  localparam logic [17:0] ALU_OR   = 18'h0000C;
  localparam logic [17:0] M_HLT    = 18'h00002;
  localparam logic [17:0] M_TRP    = 18'h00001;
  localparam logic [17:0] F_RDY    = M_MREQ | M_PINC | M_ILD;
  localparam logic [17:0] V_NONE   = 18'h00000;

  logic clk = 1'b0;
  logic clr, F_zero, mem_ready;
  logic [5:0] opcode, funct;

  logic mem_req_a, dmu_wen_a, pc_inc_a, pc_ld_a, ir_ld_a, write_a, reg_dst_a;
  logic mux_a_a, mux_b_a, mux_im_1_a, halted_a, trap_a;
  logic [1:0] mux_im_2_a, bus_sel_a, alu_op_a, trap_code_a;
  logic [3:0] instr_retired_a;

  logic mem_req_b, dmu_wen_b, pc_inc_b, pc_ld_b, ir_ld_b, write_b, reg_dst_b;
  logic mux_a_b, mux_b_b, mux_im_1_b, halted_b, trap_b;
  logic [1:0] mux_im_2_b, bus_sel_b, alu_op_b, trap_code_b;
  logic [7:0] instr_retired_b;

  logic [17:0] ctl_a, ctl_b;
  int n_checks = 0;
  int n_errors = 0;

  assign ctl_a = {mem_req_a, dmu_wen_a, pc_inc_a, pc_ld_a, ir_ld_a, write_a, reg_dst_a,
                  mux_a_a, mux_b_a, mux_im_1_a, mux_im_2_a, bus_sel_a, alu_op_a, halted_a, trap_a};
  assign ctl_b = {mem_req_b, dmu_wen_b, pc_inc_b, pc_ld_b, ir_ld_b, write_b, reg_dst_b,
                  mux_a_b, mux_b_b, mux_im_1_b, mux_im_2_b, bus_sel_b, alu_op_b, halted_b, trap_b};

  always #5 clk = ~clk;

  control_sequencer #(.TIMEOUT_CYC(4), .CNT_W(4), .TRAP_ON_ILLEGAL(1)) u_dut_a (
    .clk(clk), .clr(clr), .opcode(opcode), .funct(funct), .F_zero(F_zero),
    .mem_ready(mem_ready), .mem_req(mem_req_a), .dmu_wen(dmu_wen_a), .pc_inc(pc_inc_a),
    .pc_ld(pc_ld_a), .ir_ld(ir_ld_a), .write(write_a), .reg_dst(reg_dst_a),
    .mux_a(mux_a_a), .mux_b(mux_b_a), .mux_im_1(mux_im_1_a), .mux_im_2(mux_im_2_a),
    .bus_sel(bus_sel_a), .alu_op(alu_op_a), .halted(halted_a), .trap(trap_a),
    .trap_code(trap_code_a), .instr_retired(instr_retired_a)
  );

  control_sequencer #(.TIMEOUT_CYC(16), .CNT_W(8), .TRAP_ON_ILLEGAL(0)) u_dut_b (
    .clk(clk), .clr(clr), .opcode(opcode), .funct(funct), .F_zero(F_zero),
    .mem_ready(mem_ready), .mem_req(mem_req_b), .dmu_wen(dmu_wen_b), .pc_inc(pc_inc_b),
    .pc_ld(pc_ld_b), .ir_ld(ir_ld_b), .write(write_b), .reg_dst(reg_dst_b),
    .mux_a(mux_a_b), .mux_b(mux_b_b), .mux_im_1(mux_im_1_b), .mux_im_2(mux_im_2_b),
    .bus_sel(bus_sel_b), .alu_op(alu_op_b), .halted(halted_b), .trap(trap_b),
    .trap_code(trap_code_b), .instr_retired(instr_retired_b)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Entered just after a rising edge: drive mem_ready, check this cycle, advance.
  task automatic at(input string tag, input logic rdy, input logic [17:0] exp);
    mem_ready = rdy;
    #1;
    chk(tag, {14'd0, ctl_a}, {14'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mem_ready = 1'b0;
    clr = 1'b1;
    #1;
    clr = 1'b0;
    #1;
  endtask

  initial begin
    clr = 1'b1; opcode = 6'h00; funct = 6'h00; F_zero = 1'b0; mem_ready = 1'b0;
    #2;
    chk("rst_ctl", {14'd0, ctl_a}, {14'd0, M_MREQ});
    chk("rst_cnt", {28'd0, instr_retired_a}, 32'd0);
    chk("rst_code", {30'd0, trap_code_a}, 32'd0);
    mem_ready = 1'b1;
    #1;
    chk("rst_rdy", {14'd0, ctl_a}, {14'd0, F_RDY});
    @(posedge clk);
    #1;
    clr = 1'b0;

    // R-type ADD then OR
    opcode = 6'h00; funct = 6'h20;
    at("add_f", 1, F_RDY); at("add_d", 1, V_NONE); at("add_e", 1, V_NONE);
    at("add_wb", 1, M_WR | M_RDST | BUS_ALU);
    chk("add_cnt", {28'd0, instr_retired_a}, 32'd1);
    funct = 6'h25;
    at("or_f", 1, F_RDY); at("or_d", 1, V_NONE); at("or_e", 1, ALU_OR);
    at("or_wb", 1, M_WR | M_RDST | BUS_ALU);

    // LW with three not-ready MEM cycles
    opcode = 6'h23;
    at("lw_f", 1, F_RDY); at("lw_d", 1, V_NONE); at("lw_e", 1, IM2_IMM);
    for (int i = 0; i < 3; i++) at($sformatf("lw_mwait%0d", i), 0, M_MREQ);
    at("lw_mrdy", 1, M_MREQ);
    at("lw_wb", 1, M_WR | BUS_MEM);
    chk("lw_cnt", {28'd0, instr_retired_a}, 32'd3);

    opcode = 6'h2B;
    at("sw_f", 1, F_RDY); at("sw_d", 1, V_NONE); at("sw_e", 1, IM2_IMM);
    at("sw_mem", 1, M_MREQ | M_DMU);

    opcode = 6'h08;
    at("addi_f", 1, F_RDY); at("addi_d", 1, V_NONE); at("addi_e", 1, IM2_IMM);
    at("addi_wb", 1, M_WR | BUS_ALU);

    opcode = 6'h0F;
    at("lui_f", 1, F_RDY); at("lui_d", 1, V_NONE);
    at("lui_e", 1, M_IM1 | IM2_ONES | ALU_AND);
    at("lui_wb", 1, M_WR | BUS_ALU);

    opcode = 6'h04; F_zero = 1'b1;
    at("beq1_f", 1, F_RDY); at("beq1_d", 1, V_NONE); at("beq1_e", 1, ALU_SUB | M_PLD);
    F_zero = 1'b0;
    at("beq0_f", 1, F_RDY); at("beq0_d", 1, V_NONE); at("beq0_e", 1, ALU_SUB);
    chk("beq_cnt", {28'd0, instr_retired_a}, 32'd8);

    opcode = 6'h02;
    at("j_f", 1, F_RDY); at("j_d", 1, M_PLD);

    // Fetch ready arrives exactly on the 4th cycle: no timeout
    for (int i = 0; i < 3; i++) at($sformatf("late_fw%0d", i), 0, M_MREQ);
    at("late_frdy", 1, F_RDY);
    at("late_d", 1, M_PLD);
    chk("late_cnt", {28'd0, instr_retired_a}, 32'd10);

    for (int i = 0; i < 5; i++) begin
      at("jrun_f", 1, F_RDY); at("jrun_d", 1, M_PLD);
    end
    chk("pre15_cnt", {28'd0, instr_retired_a}, 32'd15);

    // clr during an SW memory access
    opcode = 6'h2B;
    at("swc_f", 1, F_RDY); at("swc_d", 1, V_NONE); at("swc_e", 1, IM2_IMM);
    mem_ready = 1'b0;
    #1;
    chk("swc_mem", {14'd0, ctl_a}, {14'd0, M_MREQ | M_DMU});
    clr = 1'b1;
    #1;
    chk("swc_clr_ctl", {14'd0, ctl_a}, {14'd0, M_MREQ});
    chk("swc_clr_cnt", {28'd0, instr_retired_a}, 32'd0);
    clr = 1'b0;
    #1;

    // 16 retirements wrap the 4-bit counter
    opcode = 6'h02;
    for (int i = 0; i < 16; i++) begin
      at("wrap_f", 1, F_RDY); at("wrap_d", 1, M_PLD);
      if (i == 14) chk("wrap15_cnt", {28'd0, instr_retired_a}, 32'd15);
    end
    chk("wrap_cnt_a", {28'd0, instr_retired_a}, 32'd0);
    chk("wrap_cnt_b", {24'd0, instr_retired_b}, 32'd16);

    // Illegal opcode: A traps, B retires as NOP
    opcode = 6'h3E;
    at("ill_f", 1, F_RDY); at("ill_d", 1, V_NONE);
    mem_ready = 1'b1;
    #1;
    chk("ill_a_ctl", {14'd0, ctl_a}, {14'd0, M_TRP});
    chk("ill_a_code", {30'd0, trap_code_a}, 32'd3);
    chk("ill_b_ctl", {14'd0, ctl_b}, {14'd0, F_RDY});
    chk("ill_b_cnt", {24'd0, instr_retired_b}, 32'd17);
    opcode = 6'h00; funct = 6'h21;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("illf_b_cnt", {24'd0, instr_retired_b}, 32'd18);
    chk("illf_a_ctl", {14'd0, ctl_a}, {14'd0, M_TRP});
    chk("illf_a_cnt", {28'd0, instr_retired_a}, 32'd0);

    // Fetch timeout
    do_reset();
    for (int i = 0; i < 4; i++) at($sformatf("fto_w%0d", i), 0, M_MREQ);
    mem_ready = 1'b1;
    #1;
    chk("fto_ctl", {14'd0, ctl_a}, {14'd0, M_TRP});
    chk("fto_code", {30'd0, trap_code_a}, 32'd1);
    chk("fto_cnt", {28'd0, instr_retired_a}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("fto_hold", {14'd0, ctl_a}, {14'd0, M_TRP});
    end

    // Memory timeout
    do_reset();
    opcode = 6'h23;
    at("mto_f", 1, F_RDY); at("mto_d", 1, V_NONE); at("mto_e", 1, IM2_IMM);
    for (int i = 0; i < 4; i++) at($sformatf("mto_w%0d", i), 0, M_MREQ);
    #1;
    chk("mto_ctl", {14'd0, ctl_a}, {14'd0, M_TRP});
    chk("mto_code", {30'd0, trap_code_a}, 32'd2);

    // HALT is absorbing and quiet
    do_reset();
    opcode = 6'h3F;
    at("hlt_f", 1, F_RDY); at("hlt_d", 1, V_NONE);
    for (int i = 0; i < 10; i++) at($sformatf("hlt_%0d", i), i[0], M_HLT);
    chk("hlt_code", {30'd0, trap_code_a}, 32'd0);
    chk("hlt_b_ctl", {14'd0, ctl_b}, {14'd0, M_HLT});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
